// File: rtl/sr_pkg.sv
// sr_pkg: shared state encoding and frame width for the 74HC595 arbiter.
package sr_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, ACK} sr_state_t;
  localparam int SR_BITS = 8;
endpackage

// File: rtl/sr_tx.sv
// sr_tx: serialises one byte MSB first onto SER/SRCLK, then pulses RCLK.
// Ports: clk, rst_n (sync active-low), start_i (load byte_i and begin),
// byte_i (frame), busy_o (not IDLE), done_o (single ACK cycle),
// ser_o/srclk_o/rclk_o (registered pins to the shift register).
module sr_tx import sr_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [SR_BITS-1:0] byte_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               ser_o,
  output logic               srclk_o,
  output logic               rclk_o
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(SR_BITS);
  sr_state_t state_q, state_d;
  logic ser_q, ser_d, srclk_q, srclk_d, rclk_q, rclk_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [SR_BITS-1:0] sh_q, sh_d;
  logic ph_end, last;
  assign ph_end = ph_q == PW'(CLK_DIV - 1);
  assign last = bit_q == BW'(SR_BITS - 1);
  always_comb begin
    state_d = state_q;
    ser_d = ser_q;
    srclk_d = srclk_q;
    rclk_d = rclk_q;
    bit_d = bit_q;
    ph_d = ph_q;
    sh_d = sh_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = SHIFT;
        ser_d = byte_i[SR_BITS-1];
        sh_d = {byte_i[SR_BITS-2:0], 1'b0};
        srclk_d = 1'b0;
        bit_d = '0;
        ph_d = '0;
      end
      SHIFT: begin
        ph_d = ph_end ? '0 : ph_q + 1'b1;
        if (ph_end) begin
          srclk_d = !srclk_q;
          // SER only moves on the falling SRCLK edge, so it is stable at every rise
          if (srclk_q) begin
            bit_d = bit_q + 1'b1;
            ser_d = last ? 1'b0 : sh_q[SR_BITS-1];
            sh_d = sh_q << 1;
            state_d = last ? LATCH : SHIFT;
          end
        end
      end
      LATCH: begin
        // one settle cycle with RCLK low after the last SRCLK fall, then CLK_DIV cycles high
        rclk_d = !rclk_q || !ph_end;
        ph_d = rclk_q && !ph_end ? ph_q + 1'b1 : '0;
        state_d = rclk_q && ph_end ? ACK : LATCH;
      end
      ACK: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ser_q <= 1'b0;
      srclk_q <= 1'b0;
      rclk_q <= 1'b0;
      bit_q <= '0;
      ph_q <= '0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      ser_q <= ser_d;
      srclk_q <= srclk_d;
      rclk_q <= rclk_d;
      bit_q <= bit_d;
      ph_q <= ph_d;
      sh_q <= sh_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = state_q == ACK;
  assign ser_o = ser_q;
  assign srclk_o = srclk_q;
  assign rclk_o = rclk_q;
endmodule

// File: rtl/sr_arbiter.sv
// sr_arbiter: round-robin sharing of one 74HC595 chain among N_REQ requesters.
// Ports: clk, rst_n (sync active-low), req/data (per-requester level and byte),
// ack (one-cycle completion), grant (one-hot during transfer), busy,
// SER/SRCLK/RCLK (shift register pins).
module sr_arbiter import sr_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*8-1:0]   data,
  output logic [N_REQ-1:0]     ack,
  output logic [N_REQ-1:0]     grant,
  output logic                 busy,
  output logic                 SER,
  output logic                 SRCLK,
  output logic                 RCLK
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] ptr_q, ptr_d, win;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic start, done;
  always_comb begin
    win = ptr_q;
    // scan farthest-first so the index closest after the pointer wins
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr_q) + k) % N_REQ]) win = IW'((int'(ptr_q) + k) % N_REQ);
  end
  assign start = !busy && |req;
  assign ptr_d = start ? (win == IW'(N_REQ - 1) ? '0 : win + 1'b1) : ptr_q;
  assign grant_d = start ? N_REQ'(1) << win : done ? '0 : grant_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
      grant_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      grant_q <= grant_d;
    end
  end
  sr_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk(clk),
    .rst_n(rst_n),
    .start_i(start),
    .byte_i(data[8*win +: SR_BITS]),
    .busy_o(busy),
    .done_o(done),
    .ser_o(SER),
    .srclk_o(SRCLK),
    .rclk_o(RCLK)
  );
  assign grant = grant_q;
  assign ack = done ? grant_q : '0;
endmodule
